instr_decode_stage: RTL and testbench
=====================================

Name: instr_decode_stage

Overview:
- Decode stage directly upstream of the constant (immediate-extension) unit.
- Accepts 16-bit instruction words from fetch through a valid/ready handshake and buffers them in a small FIFO.
- Splits each word into opcode, register fields and the 6-bit immediate, and generates CS (1 = sign-extend, 0 = zero-extend).
- Presents one decoded instruction at a time to the execute side (constant unit + register file read) with its own valid/ready handshake.

Parameters:
- IW, 16, instruction width; the field map below is fixed for 16.
- DEPTH, 2, decoded-entry buffer depth; a power of two in the range 2..8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered entries (branch taken).
- in_valid  in  1  fetch presents in_instr.
- in_instr  in  IW  raw instruction word.
- in_ready  out  1  stage can accept a word this cycle.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  execute consumes the head entry this cycle.
- opcode  out  4  head opcode.
- rd  out  3  destination register.
- rs  out  3  source register.
- Immediate  out  6  raw immediate, fed unmodified to the constant unit.
- CS  out  1  extension select for the constant unit.
- uses_imm  out  1  ALU operand B comes from the extended immediate.
- illegal  out  1  opcode is unassigned.

Behaviour:
- Field map: opcode = in_instr[15:12], rd = [11:9], rs = [8:6], Immediate = [5:0].
- Decode table, opcode -> CS / uses_imm / illegal:
  - 0x0-0x3 (register ALU ops): 0/0/0.
  - 0x4 ADDI, 0x5 LW, 0x6 SW, 0x7 BEQ: 1/1/0.
  - 0x8 ANDI, 0x9 ORI, 0xA XORI: 0/1/0.
  - 0xB LUI6: 0/1/0.
  - 0xC-0xF: 0/0/1.
- Decode is performed at enqueue. Each buffer entry stores opcode, rd, rs, Immediate, CS, uses_imm and illegal.
- Outputs are driven from the head entry with no combinational path from in_instr.
- Latency: a word accepted in cycle N appears with out_valid=1 in cycle N+1 when the buffer was empty.
- Throughput: 1 word/cycle when out_ready is held high.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Storage: circular buffer with write pointer, read pointer (log2 DEPTH bits, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits).
- in_ready = reset_n && (count != DEPTH), combinational from registered count. The full state blocks pushes even when a pop happens in the same cycle; there is no pass-through.
- out_valid = (count != 0).
- Push and pop in the same cycle with count between 1 and DEPTH-1: count is unchanged and both pointers advance.
- Empty with push: count becomes 1, and the head is the new entry in the next cycle.
- flush=1: at the next edge, count and both pointers go to 0. Any push or pop in that cycle is discarded; flush has priority over push and pop.
- Reset (reset_n low at an edge): count and pointers go to 0.
- All outputs read as zero while out_valid=0. Stale data is masked, not held.
- in_ready is 0 while reset_n is low.
- Reset asserted mid-stream drops all entries; no partial entry survives.
- Illegal opcodes are buffered and forwarded normally with illegal=1. Execute decides trap behaviour; this stage never stalls on them.

Decomposition:
- Shared package isa_pkg:
  - opcode localparams (OP_ADDI=4'h4, etc.);
  - field bit positions;
  - a decoded-instruction struct/bundle width constant (DEC_W=17).
- One natural sub-module, instr_field_decoder: purely combinational instruction -> decoded bundle. The stage instantiates it on the input side and stores its output in the FIFO.

Test Plan:
- Reset, then push 0x4A73 with out_ready=0 -> next cycle out_valid=1, opcode=4, rd=5, rs=1, Immediate=6'b110011, CS=1, uses_imm=1, illegal=0.
- Push 0x8256 -> opcode=8, rd=1, rs=1, Immediate=6'b010110, CS=0, uses_imm=1.
- Fill with out_ready=0: after 2 pushes in_ready=0. A third word presented is not accepted. Then out_ready=1 for 2 cycles -> the words drain in order and out_valid drops.
- Streaming with in_valid=out_ready=1 for 10 words (0x4000..0x4009) -> one output per cycle, in order, Immediate 0..9, count never exceeds 1.
- flush asserted with 2 buffered entries and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the word presented during the flush is lost.
- Push 0xF123 -> illegal=1, CS=0, uses_imm=0. Also: reset_n=0 asserted with 1 entry buffered -> next cycle out_valid=0 and all outputs 0.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcode values, instruction field
// positions and the decoded-instruction bundle stored in the decode buffer.
package isa_pkg;

   localparam int IW = 16;

   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LW   = 4'h5;
   localparam logic [3:0] OP_SW   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_ANDI = 4'h8;
   localparam logic [3:0] OP_ORI  = 4'h9;
   localparam logic [3:0] OP_XORI = 4'hA;
   localparam logic [3:0] OP_LUI6 = 4'hB;

   localparam int OPC_LSB = 12;
   localparam int RD_LSB  = 9;
   localparam int RS_LSB  = 6;
   localparam int IMM_LSB = 0;

   // DEC_W covers the instruction fields plus CS; the two flags ride alongside.
   localparam int DEC_W   = 17;
   localparam int ENTRY_W = DEC_W + 2;

   typedef struct packed {
      logic [3:0] opcode;
      logic [2:0] rd;
      logic [2:0] rs;
      logic [5:0] imm;
      logic       cs;
      logic       uses_imm;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/instr_field_decoder.sv
// Purely combinational split of a raw instruction word into the decoded bundle,
// including the immediate extension select and operand/legality flags.
module instr_field_decoder
   import isa_pkg::*;
(
   input  logic [IW-1:0] instr,
   output dec_t          dec
);

   always_comb begin
      dec          = '0;
      dec.opcode   = instr[OPC_LSB +: 4];
      dec.rd       = instr[RD_LSB +: 3];
      dec.rs       = instr[RS_LSB +: 3];
      dec.imm      = instr[IMM_LSB +: 6];
      case (instr[OPC_LSB +: 4])
         OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
            dec.cs       = 1'b1;
            dec.uses_imm = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI6: begin
            dec.uses_imm = 1'b1;
         end
         4'hC, 4'hD, 4'hE, 4'hF: begin
            dec.illegal  = 1'b1;
         end
         default: begin
            // register-register ALU ops: no immediate involvement
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: decodes fetched words on entry and buffers them in a small
// circular FIFO, presenting one decoded head entry to execute.
module instr_decode_stage
   import isa_pkg::*;
#(
   parameter int IW_P  = IW,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [IW_P-1:0] in_instr,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      opcode,
   output logic [2:0]      rd,
   output logic [2:0]      rs,
   output logic [5:0]      Immediate,
   output logic            CS,
   output logic            uses_imm,
   output logic            illegal
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   dec_t          mem [DEPTH];
   dec_t          dec_in;
   dec_t          head;
   logic          push;
   logic          pop;

   instr_field_decoder u_dec (
      .instr (in_instr[IW-1:0]),
      .dec   (dec_in)
   );

   // A full buffer refuses input even when a pop happens this cycle.
   assign in_ready  = reset_n && (count_reg != CW'(DEPTH));
   assign out_valid = (count_reg != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && reset_n && !flush) mem[wr_ptr_reg] <= dec_in;
   end

   // Stale entries are masked rather than held once the buffer is empty.
   assign head = out_valid ? mem[rd_ptr_reg] : '0;

   assign opcode    = head.opcode;
   assign rd        = head.rd;
   assign rs        = head.rs;
   assign Immediate = head.imm;
   assign CS        = head.cs;
   assign uses_imm  = head.uses_imm;
   assign illegal   = head.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: a decode vector table plus hand-written
// fill, streaming, flush and reset sequences.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_instr = '0;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  opcode;
   logic [2:0]  rd;
   logic [2:0]  rs;
   logic [5:0]  Immediate;
   logic        CS;
   logic        uses_imm;
   logic        illegal;

   int tests = 0;
   int fails = 0;

   instr_decode_stage dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .opcode    (opcode),
      .rd        (rd),
      .rs        (rs),
      .Immediate (Immediate),
      .CS        (CS),
      .uses_imm  (uses_imm),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [5:0]  imm;
      logic        cs;
      logic        ui;
      logic        il;
   } vec_t;

   vec_t vecs [10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, "_bundle"}, {15'b0, opcode, rd, rs, Immediate, CS, uses_imm, illegal}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{16'h4A73, 4'h4, 3'd5, 3'd1, 6'b110011, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{16'h8256, 4'h8, 3'd1, 3'd1, 6'b010110, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{16'hF123, 4'hF, 3'd0, 3'd4, 6'h23,     1'b0, 1'b0, 1'b1};
      vecs[3] = '{16'h0123, 4'h0, 3'd0, 3'd4, 6'h23,     1'b0, 1'b0, 1'b0};
      vecs[4] = '{16'h5FFF, 4'h5, 3'd7, 3'd7, 6'h3F,     1'b1, 1'b1, 1'b0};
      vecs[5] = '{16'hB03F, 4'hB, 3'd0, 3'd0, 6'h3F,     1'b0, 1'b1, 1'b0};
      vecs[6] = '{16'hC000, 4'hC, 3'd0, 3'd0, 6'h00,     1'b0, 1'b0, 1'b1};
      vecs[7] = '{16'hA555, 4'hA, 3'd2, 3'd5, 6'h15,     1'b0, 1'b1, 1'b0};
      vecs[8] = '{16'h7E80, 4'h7, 3'd7, 3'd2, 6'h00,     1'b1, 1'b1, 1'b0};
      vecs[9] = '{16'h3FC1, 4'h3, 3'd7, 3'd7, 6'h01,     1'b0, 1'b0, 1'b0};

      // Reset state
      step();
      step();
      check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
      check_zero_outputs("rst");
      reset_n = 1'b1;
      step();
      check("rst_in_ready_high", {31'b0, in_ready}, 32'd1);
      $display("[TB] reset released");

      // Decode table: single word through an empty buffer, then drained
      for (int i = 0; i < 10; i++) begin
         in_valid  = 1'b1;
         in_instr  = vecs[i].instr;
         out_ready = 1'b0;
         step();
         in_valid = 1'b0;
         check("vec_valid",    {31'b0, out_valid}, 32'd1);
         check("vec_opcode",   {28'b0, opcode},    {28'b0, vecs[i].op});
         check("vec_rd",       {29'b0, rd},        {29'b0, vecs[i].rd});
         check("vec_rs",       {29'b0, rs},        {29'b0, vecs[i].rs});
         check("vec_imm",      {26'b0, Immediate}, {26'b0, vecs[i].imm});
         check("vec_cs",       {31'b0, CS},        {31'b0, vecs[i].cs});
         check("vec_uses_imm", {31'b0, uses_imm},  {31'b0, vecs[i].ui});
         check("vec_illegal",  {31'b0, illegal},   {31'b0, vecs[i].il});
         $display("[TB] vec %0d instr=%h op=%h rd=%0d rs=%0d imm=%h cs=%b ui=%b il=%b",
                  i, vecs[i].instr, opcode, rd, rs, Immediate, CS, uses_imm, illegal);
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
         check_zero_outputs("vec_drain");
      end

      // Fill to full, then a pop while full must not admit the waiting word
      in_valid = 1'b1;
      in_instr = 16'h1234;
      step();
      in_instr = 16'h2345;
      step();
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      in_instr = 16'h3456;
      step();
      check("full_head_a", {28'b0, opcode}, 32'h1);
      check("full_still_full", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("drain_head_b", {28'b0, opcode}, 32'h2);
      check("drain_b_rd", {29'b0, rd}, 32'd1);
      check("drain_b_imm", {26'b0, Immediate}, 32'h05);
      step();
      check("drain_empty", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;
      $display("[TB] fill/drain sequence done");

      // Streaming: one word per cycle, buffer never above one entry
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_instr = 16'h4000 + 16'(i);
         step();
         check("stream_valid", {31'b0, out_valid}, 32'd1);
         check("stream_imm", {26'b0, Immediate}, 32'(i));
         check("stream_in_ready", {31'b0, in_ready}, 32'd1);
         $display("[TB] stream %0d imm=%0d", i, Immediate);
      end
      in_valid = 1'b0;
      step();
      check("stream_empty", {31'b0, out_valid}, 32'd0);
      out_ready = 1'b0;

      // Flush with two buffered entries and a word on the input
      in_valid = 1'b1;
      in_instr = 16'h1111;
      step();
      in_instr = 16'h2222;
      step();
      check("pre_flush_full", {31'b0, in_ready}, 32'd0);
      flush    = 1'b1;
      in_instr = 16'h3333;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_empty", {31'b0, out_valid}, 32'd0);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      check_zero_outputs("flush_lost");
      $display("[TB] flush sequence done");

      // Reset asserted with one entry buffered
      in_valid = 1'b1;
      in_instr = 16'h4A73;
      step();
      in_valid = 1'b0;
      check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      reset_n = 1'b0;
      step();
      check_zero_outputs("midrst");
      check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      reset_n = 1'b1;
      step();
      check("post_rst_empty", {31'b0, out_valid}, 32'd0);
      check("post_rst_ready", {31'b0, in_ready}, 32'd1);
      $display("[TB] mid-stream reset done");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
